fifo_wr_arb: RTL

FIFO_WR_ARB -- requirements
Module: fifo_wr_arb

---
 rtl/fifo_arb_pkg.sv | 19 +
 rtl/rr_pick.sv | 37 +++
 rtl/fifo_wr_arb.sv | 119 +++++++++++
 3 files changed

// File: rtl/fifo_arb_pkg.sv
// Shared types and defaults for the FIFO write arbiter.
// Holds the arbiter state enum and default parameter values.
package fifo_arb_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    localparam int NREQ_DEF      = 4;
    localparam int D_W_DEF       = 32;
    localparam int MAX_BURST_DEF = 4;

    // Index width for n entries, never narrower than one bit.
    function automatic int idx_w(int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/rr_pick.sv
// Round-robin picker: first set request at or above rr_ptr,
// wrapping from NREQ-1 back to 0.
module rr_pick
    import fifo_arb_pkg::*;
#(
    parameter int NREQ = NREQ_DEF,
    parameter int GW   = idx_w(NREQ)
) (
    input  logic [NREQ-1:0] req,
    input  logic [GW-1:0]   rr_ptr,
    output logic [GW-1:0]   winner,
    output logic            any_valid
);

    int          w_k;
    logic [GW-1:0] w_idx;

    // Walk offsets 0..NREQ-1 from the pointer; keep the first hit.
    always_comb begin
        winner    = '0;
        any_valid = 1'b0;
        w_k       = 0;
        w_idx     = '0;
        for (int i = 0; i < NREQ; i++) begin
            w_k = int'(rr_ptr) + i;
            if (w_k >= NREQ) begin
                w_k = w_k - NREQ;
            end
            w_idx = GW'(w_k);
            if (!any_valid && req[w_idx]) begin
                winner    = w_idx;
                any_valid = 1'b1;
            end
        end
    end

endmodule

// File: rtl/fifo_wr_arb.sv
// Round-robin burst arbiter feeding a shared FIFO write port.
// Owner is latched in IDLE; beats pass through combinationally in GRANT.
module fifo_wr_arb
    import fifo_arb_pkg::*;
#(
    parameter int NREQ      = NREQ_DEF,
    parameter int D_W       = D_W_DEF,
    parameter int MAX_BURST = MAX_BURST_DEF,
    localparam int GW       = idx_w(NREQ),
    localparam int BW       = $clog2(MAX_BURST + 1)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [NREQ-1:0]       req_valid,
    input  logic signed [D_W-1:0] req_data [NREQ],
    input  logic [NREQ-1:0]       req_last,
    output logic [NREQ-1:0]       req_ready,
    input  logic                  fifo_full,
    output logic                  fifo_write,
    output logic signed [D_W-1:0] fifo_data,
    output logic [GW-1:0]         grant_id,
    output logic                  busy
);

    state_t        r_state;
    state_t        w_next;
    logic [GW-1:0] r_rr_ptr;
    logic [GW-1:0] r_grant_id;
    logic [BW-1:0] r_beat_cnt;
    logic [GW-1:0] w_winner;
    logic [GW-1:0] w_ptr_inc;
    logic          w_any;
    logic          w_gv;
    logic          w_gl;
    logic          w_acc;
    logic          w_end;

    rr_pick #(
        .NREQ (NREQ),
        .GW   (GW)
    ) u_rr_pick (
        .req       (req_valid),
        .rr_ptr    (r_rr_ptr),
        .winner    (w_winner),
        .any_valid (w_any)
    );

    assign w_gv  = req_valid[r_grant_id];
    assign w_gl  = req_last[r_grant_id];
    assign w_acc = (r_state == GRANT) && w_gv && !fifo_full;
    assign w_end = w_acc &&
                   (w_gl || (r_beat_cnt == BW'(MAX_BURST - 1)));

    assign w_ptr_inc = (r_grant_id == GW'(NREQ - 1)) ?
                       '0 : r_grant_id + GW'(1);

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next state: grant on any request, release on last/limit/drop.
    always_comb begin
        w_next = r_state;
        unique case (r_state)
            IDLE: begin
                if (w_any) begin
                    w_next = GRANT;
                end
            end
            GRANT: begin
                if (!w_gv || w_end) begin
                    w_next = IDLE;
                end
            end
            default: w_next = IDLE;
        endcase
    end

    // Owner, beat counter and round-robin pointer bookkeeping.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_grant_id <= '0;
            r_beat_cnt <= '0;
            r_rr_ptr   <= '0;
        end else begin
            if (r_state == IDLE && w_any) begin
                r_grant_id <= w_winner;
                r_beat_cnt <= '0;
            end
            if (w_acc) begin
                r_beat_cnt <= r_beat_cnt + BW'(1);
            end
            if (r_state == GRANT && w_next == IDLE) begin
                r_rr_ptr <= w_ptr_inc;
            end
        end
    end

    // Outputs: only the owner sees ready, and only when FIFO has room.
    always_comb begin
        req_ready  = '0;
        fifo_write = 1'b0;
        busy       = 1'b0;
        if (r_state == GRANT) begin
            busy                  = 1'b1;
            req_ready[r_grant_id] = w_gv && !fifo_full;
            fifo_write            = w_acc;
        end
    end

    assign fifo_data = req_data[r_grant_id];
    assign grant_id  = r_grant_id;

endmodule
